// File: rtl/cache_opr_sched.sv
// Round-robin owner of the serial cache operation pipeline.
// Launches each stage in turn and aborts a stage that never reports done.
module cache_opr_sched #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_STAGES    = 8,
  parameter int STAGE_TIMEOUT = 32,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int SW  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [SW-1:0]         cur_stage,
  output logic                  busy,
  output logic                  opr_finished,
  output logic                  timeout_err,
  output logic [SW-1:0]         abort_stage
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t                  state;
  logic [IDW-1:0]          ptr;
  logic [7:0]              timer;
  logic                    aborted;

  logic [NUM_REQ-1:0]      win_oh;
  logic [IDW-1:0]          win_id;
  logic                    win_vld;
  logic [IDW:0]            idx;
  logic [NUM_STAGES-1:0]   cur_oh;
  logic                    done_cur;
  logic                    last_stage;
  logic                    tmo;

  // first requester at or above ptr, wrapping at NUM_REQ
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ))
        idx = idx - (IDW+1)'(NUM_REQ);
      if (!win_vld && req[idx[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[IDW-1:0];
      end
    end
    win_oh = win_vld ? (NUM_REQ'(1) << win_id) : '0;
  end

  assign cur_oh     = NUM_STAGES'(1) << cur_stage;
  assign done_cur   = |(stage_done & cur_oh);
  assign last_stage = cur_stage == SW'(NUM_STAGES-1);
  assign tmo        = timer == 8'(STAGE_TIMEOUT-1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= S_IDLE;
      ptr         <= '0;
      timer       <= '0;
      aborted     <= 1'b0;
      gnt         <= '0;
      gnt_id      <= '0;
      cur_stage   <= '0;
      abort_stage <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            state     <= S_LAUNCH;
            gnt       <= win_oh;
            gnt_id    <= win_id;
            cur_stage <= '0;
            aborted   <= 1'b0;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (done_cur) begin
            if (last_stage) begin
              state <= S_FINISH;
            end else begin
              cur_stage <= cur_stage + 1'b1;
              state     <= S_LAUNCH;
            end
          end else if (tmo) begin
            abort_stage <= cur_stage;
            aborted     <= 1'b1;
            state       <= S_FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FINISH: begin
          state     <= S_IDLE;
          gnt       <= '0;
          cur_stage <= '0;
          ptr       <= (gnt_id == IDW'(NUM_REQ-1)) ? '0
                     : gnt_id + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = state != S_IDLE;
  assign opr_finished = state == S_FINISH;
  assign timeout_err  = opr_finished & aborted;
  assign stage_start  = (state == S_LAUNCH) ? cur_oh : '0;

endmodule

// File: tb/tb_cache_opr_sched.sv
// Randomized bench for cache_opr_sched against a per-operation timing model.
// A stage responder answers each start pulse after a chosen delay.
module tb_cache_opr_sched;

  localparam int NR = 4;
  localparam int NS = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_id;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic [2:0]    cur_stage;
  logic          busy;
  logic          opr_finished;
  logic          timeout_err;
  logic [2:0]    abort_stage;

  cache_opr_sched #(
    .NUM_REQ(NR), .NUM_STAGES(NS), .STAGE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstb(rstb), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .stage_start(stage_start),
    .stage_done(stage_done), .cur_stage(cur_stage),
    .busy(busy), .opr_finished(opr_finished),
    .timeout_err(timeout_err), .abort_stage(abort_stage)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs
  int dly[NS];
  bit stray;
  bit drop_req;
  int rst_stage = -1;

  // observations of one operation
  logic [NR-1:0] o_gnt;
  logic [1:0]    o_gid;
  int            o_start_at[NS];
  logic [2:0]    o_cur_at[NS];
  int            o_fin_at;
  int            o_fin_cnt;
  logic          o_to;
  logic [2:0]    o_abort;
  bit            o_gnt_moved;
  logic          o_busy_after;
  logic [22:0]   o_rst_bits;

  // reference model
  int m_ptr   = 0;
  int m_abort = 0;
  int e_gid;
  int e_start_at[NS];
  int e_fin;
  bit e_to;

  function automatic void set_dly(input int v);
    for (int s = 0; s < NS; s++) dly[s] = v;
  endfunction

  task automatic model_op(input logic [NR-1:0] rq);
    int t;
    e_gid = -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (e_gid < 0 && rq[k]) e_gid = k;
    end
    e_to = 0;
    t = 1;
    for (int s = 0; s < NS; s++) begin
      e_start_at[s] = -1;
      if (!e_to) begin
        e_start_at[s] = t;
        if (dly[s] <= TO) begin
          t += 1 + dly[s];
        end else begin
          t += 1 + TO;
          e_to = 1;
          m_abort = s;
        end
      end
    end
    e_fin = t;
    m_ptr = (e_gid + 1) % NR;
  endtask

  // cycle 0 is the current cycle; returns #1 into the IDLE cycle after FINISH
  task automatic run_op(input logic [NR-1:0] rq);
    int due[NS];
    int t;
    logic [NS-1:0] d;
    req = rq;
    o_fin_at = -1;
    o_fin_cnt = 0;
    o_to = 1'b0;
    o_gnt_moved = 0;
    o_busy_after = 1'bx;
    o_rst_bits = '1;
    o_gnt = 'x;
    o_gid = 'x;
    o_abort = 'x;
    for (int s = 0; s < NS; s++) begin
      due[s] = -1;
      o_start_at[s] = -1;
      o_cur_at[s] = 'x;
    end
    t = 0;
    while (t < 700) begin
      @(posedge clk);
      #1;
      t++;
      if (t == 1) begin
        o_gnt = gnt;
        o_gid = gnt_id;
      end else if (busy && gnt !== o_gnt) begin
        o_gnt_moved = 1;
      end
      for (int s = 0; s < NS; s++)
        if (stage_start[s]) begin
          o_start_at[s] = t;
          o_cur_at[s] = cur_stage;
          due[s] = t + dly[s];
        end
      if (opr_finished) begin
        o_fin_cnt++;
        o_fin_at = t;
        o_to = timeout_err;
        o_abort = abort_stage;
      end
      if (o_fin_at > 0 && t == o_fin_at + 1) begin
        o_busy_after = busy;
        break;
      end
      if (drop_req && t == 3) req = '0;
      d = '0;
      for (int s = 0; s < NS; s++)
        if (due[s] == t) d[s] = 1'b1;
      if (stray && t == 1) d[0] = 1'b1;
      if (stray && o_start_at[2] > 0 && t == o_start_at[2] + 1)
        d[5] = 1'b1;
      stage_done = d;
      if (rst_stage >= 0 && o_start_at[rst_stage] > 0 &&
          t == o_start_at[rst_stage] + 2) begin
        #2 rstb = 1'b0;
        #1 o_rst_bits = {gnt, gnt_id, stage_start, cur_stage, busy,
                         opr_finished, timeout_err, abort_stage};
        break;
      end
    end
    stage_done = '0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (gnt !== '0 || gnt_id !== '0) begin
      n_fail++;
      $display("FAIL reset_gnt: got gnt=%b id=%0d expected 0", gnt, gnt_id);
    end
    n_tests++;
    if (stage_start !== '0 || cur_stage !== '0) begin
      n_fail++;
      $display("FAIL reset_stage: got start=%b cur=%0d expected 0",
               stage_start, cur_stage);
    end
    n_tests++;
    if (busy !== 1'b0 || opr_finished !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b fin=%b to=%b expected 0",
               busy, opr_finished, timeout_err);
    end
    n_tests++;
    if (abort_stage !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d expected 0", abort_stage);
    end
    @(negedge clk) rstb = 1'b1;
    @(posedge clk);
    #1;
    m_ptr = 0;
    m_abort = 0;
  endtask

  task automatic test_single();
    int bad;
    set_dly(1);
    stray = 0;
    drop_req = 0;
    model_op(4'b0001);
    run_op(4'b0001);
    req = '0;
    n_tests++;
    if (int'(o_gnt) != (1 << e_gid) || int'(o_gid) != e_gid) begin
      n_fail++;
      $display("FAIL single_gnt: got %b/%0d expected id %0d",
               o_gnt, o_gid, e_gid);
    end
    for (int s = 0; s < NS; s++) begin
      n_tests++;
      if (o_start_at[s] != e_start_at[s] || int'(o_cur_at[s]) != s) begin
        n_fail++;
        $display("FAIL single_start%0d: got cycle %0d cur %0d expected %0d",
                 s, o_start_at[s], o_cur_at[s], e_start_at[s]);
      end
    end
    n_tests++;
    if (o_fin_at != e_fin || o_fin_cnt != 1 || o_to !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fin: got cycle %0d cnt %0d to %b expected %0d",
               o_fin_at, o_fin_cnt, o_to, e_fin);
    end
    n_tests++;
    if (o_busy_after !== 1'b0 || o_gnt_moved) begin
      bad = o_gnt_moved;
      n_fail++;
      $display("FAIL single_idle: got busy %b moved %0d expected 0 0",
               o_busy_after, bad);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk) rstb = 1'b0;
    @(negedge clk) rstb = 1'b1;
    @(posedge clk);
    #1;
    m_ptr = 0;
    m_abort = 0;
    set_dly(1);
    stray = 0;
    drop_req = 0;
    for (int op = 0; op < 5; op++) begin
      model_op(4'b1111);
      run_op(4'b1111);
      n_tests++;
      if (int'(o_gid) != e_gid || int'(o_gnt) != (1 << e_gid)) begin
        n_fail++;
        $display("FAIL rr_order%0d: got id %0d expected %0d",
                 op, o_gid, e_gid);
      end
      n_tests++;
      if (o_fin_at != e_fin || o_busy_after !== 1'b0 || o_gnt_moved) begin
        n_fail++;
        $display("FAIL rr_len%0d: got fin %0d busy_after %b expected %0d 0",
                 op, o_fin_at, o_busy_after, e_fin);
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    set_dly(1);
    dly[3] = 1000;
    stray = 0;
    drop_req = 0;
    model_op(4'b0100);
    run_op(4'b0100);
    n_tests++;
    if (o_fin_at != e_fin || o_fin_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_fin: got cycle %0d cnt %0d expected %0d 1",
               o_fin_at, o_fin_cnt, e_fin);
    end
    n_tests++;
    if (o_to !== 1'b1 || int'(o_abort) != 3) begin
      n_fail++;
      $display("FAIL timeout_err: got to %b stage %0d expected 1 3",
               o_to, o_abort);
    end
    n_tests++;
    if (o_start_at[4] != -1 || o_start_at[5] != -1 ||
        o_start_at[6] != -1 || o_start_at[7] != -1) begin
      n_fail++;
      $display("FAIL timeout_later: got s4 at %0d s7 at %0d expected -1",
               o_start_at[4], o_start_at[7]);
    end
  endtask

  task automatic test_stray();
    int bad;
    set_dly(1);
    stray = 1;
    drop_req = 0;
    model_op(4'b1000);
    run_op(4'b1000);
    stray = 0;
    bad = 0;
    for (int s = 0; s < NS; s++)
      if (o_start_at[s] != e_start_at[s]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stray_seq: got %0d wrong starts expected 0", bad);
    end
    n_tests++;
    if (o_fin_at != e_fin || o_to !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_fin: got %0d to %b expected %0d 0",
               o_fin_at, o_to, e_fin);
    end
  endtask

  task automatic test_done_wins();
    set_dly(1);
    dly[3] = TO;
    stray = 0;
    drop_req = 1;
    model_op(4'b0010);
    run_op(4'b0010);
    drop_req = 0;
    n_tests++;
    if (o_fin_at != e_fin || o_fin_cnt != 1 || o_to !== 1'b0) begin
      n_fail++;
      $display("FAIL done_wins: got fin %0d cnt %0d to %b expected %0d 1 0",
               o_fin_at, o_fin_cnt, o_to, e_fin);
    end
    n_tests++;
    if (int'(o_abort) != m_abort) begin
      n_fail++;
      $display("FAIL abort_held: got %0d expected %0d", o_abort, m_abort);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] rq;
    int bad;
    int r;
    stray = 0;
    for (int op = 0; op < 24; op++) begin
      rq = NR'($urandom_range(1, 15));
      drop_req = ($urandom_range(0, 1) == 1);
      for (int s = 0; s < NS; s++) begin
        r = $urandom_range(0, 29);
        if (r < 26) dly[s] = $urandom_range(1, 4);
        else if (r < 29) dly[s] = $urandom_range(TO - 1, TO + 1);
        else dly[s] = 1000;
      end
      model_op(rq);
      run_op(rq);
      bad = 0;
      for (int s = 0; s < NS; s++)
        if (o_start_at[s] != e_start_at[s]) bad++;
      n_tests++;
      if (int'(o_gid) != e_gid || bad != 0) begin
        n_fail++;
        $display("FAIL rand%0d_seq: got id %0d bad %0d expected id %0d 0",
                 op, o_gid, bad, e_gid);
      end
      n_tests++;
      if (o_fin_at != e_fin || o_to !== e_to || int'(o_abort) != m_abort ||
          o_busy_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_fin: got %0d/%b/%0d expected %0d/%0d/%0d",
                 op, o_fin_at, o_to, o_abort, e_fin, e_to, m_abort);
      end
    end
    drop_req = 0;
    req = '0;
  endtask

  task automatic test_reset_mid();
    int seen;
    set_dly(3);
    stray = 0;
    drop_req = 0;
    rst_stage = 4;
    model_op(4'b0001);
    run_op(4'b0001);
    rst_stage = -1;
    m_ptr = 0;
    m_abort = 0;
    req = '0;
    n_tests++;
    if (o_rst_bits !== '0 || o_fin_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_async: got %h fin %0d expected 0 0",
               o_rst_bits, o_fin_cnt);
    end
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (opr_finished !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_nofin: got %0d pulses expected 0", seen);
    end
    @(negedge clk) rstb = 1'b1;
    @(posedge clk);
    #1;
    set_dly(1);
    model_op(4'b0010);
    run_op(4'b0010);
    req = '0;
    n_tests++;
    if (int'(o_gnt) != (1 << e_gid) || o_fin_at != e_fin) begin
      n_fail++;
      $display("FAIL rst_regrant: got gnt %b fin %0d expected id %0d %0d",
               o_gnt, o_fin_at, e_gid, e_fin);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stray();
    test_done_wins();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
